// File: rtl/clkrstgen.sv
// -----------------------------------------------------------------------------
// clkrstgen -- board clock and reset generator
//
// Divides the oscillator clock CLK by a runtime-selectable integer N to make
// the system clock clk, with a one-CLK-cycle enable clk_en that marks the CLK
// cycle ending in each clk rising edge. Divisor changes go through a
// four-phase req/ack handshake and only take effect on a period boundary, so
// clk never produces a runt pulse. Also generates the system reset: asserted
// asynchronously by power_on_reset, released synchronously after a two-flop
// synchroniser plus RSTCYCLES clk periods.
//
// Ports:
//   CLK            in   oscillator clock, all flops on its rising edge
//   power_on_reset in   asynchronous active-high reset
//   div_sel        in   requested divisor N (0 and 1 are treated as 2)
//   div_req        in   four-phase request; div_sel stable while high
//   div_ack        out  four-phase acknowledge
//   clk            out  divided system clock (registered)
//   clk_en         out  high for the CLK cycle ending in a clk rise
//   reset          out  system reset, async assert, CLK-sync deassert
//   locked         out  reset low and no divisor change in progress
// -----------------------------------------------------------------------------
module clkrstgen #(
   parameter int DIVBITS     = 8,
   parameter int DEFAULT_DIV = 4,
   parameter int RSTCYCLES   = 16
) (
   input  logic               CLK,
   input  logic               power_on_reset,
   input  logic [DIVBITS-1:0] div_sel,
   input  logic               div_req,
   output logic               div_ack,
   output logic               clk,
   output logic               clk_en,
   output logic               reset,
   output logic               locked
);

   // Stretch counter holds 0 .. RSTCYCLES-1.
   localparam int SW = (RSTCYCLES < 2) ? 1 : $clog2(RSTCYCLES);

   localparam logic [SW-1:0]      STRETCH_LAST = SW'(RSTCYCLES - 1);
   localparam logic [DIVBITS-1:0] DIV_ONE      = DIVBITS'(1);
   localparam logic [DIVBITS-1:0] DIV_TWO      = DIVBITS'(2);
   localparam logic [DIVBITS-1:0] DIV_DEFAULT  = DIVBITS'(DEFAULT_DIV);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PEND,
      ST_ACK
   } hs_state_e;

   // Release synchroniser
   logic [1:0]         sync_q;

   // Divider
   logic [DIVBITS-1:0] cnt_q, cnt_d;
   logic [DIVBITS-1:0] n_q, n_d;
   logic               clk_q, clk_d;
   logic               clk_en_q, clk_en_d;
   logic               boundary;
   logic               load;

   // Reset stretch
   logic [SW-1:0]      stretch_q, stretch_d;
   logic               reset_q, reset_d;

   // Handshake
   hs_state_e          state_q;
   logic [DIVBITS-1:0] pend_q;
   logic [DIVBITS-1:0] sel_clamped;
   logic               div_ack_q;
   logic               locked_q;

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   // NOTE: every signal written here gets a value before any condition, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      boundary    = (cnt_q == n_q - DIV_ONE);
      // A pending divisor is swapped in exactly at the period boundary, so
      // the period that starts at cnt = 0 is wholly governed by the new N.
      load        = (state_q == ST_PEND) && boundary;
      n_d         = load ? pend_q : n_q;
      cnt_d       = boundary ? '0 : cnt_q + DIV_ONE;
      // clk is high for the first floor(N/2) counts of the period.
      clk_d       = (cnt_d < (n_d >> 1));
      clk_en_d    = (cnt_d == n_d - DIV_ONE);
      sel_clamped = (div_sel < DIV_TWO) ? DIV_TWO : div_sel;

      stretch_d   = stretch_q;
      reset_d     = reset_q;
      // Count clk rises (ends of clk_en pulses) only once the synchroniser
      // has released; the last one drops reset together with the clk rise.
      if (reset_q && !sync_q[1] && clk_en_q) begin
         if (stretch_q == STRETCH_LAST) begin
            reset_d = 1'b0;
         end else begin
            stretch_d = stretch_q + SW'(1);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Release synchroniser: set by power_on_reset, shifts in zeros.
   // --------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge power_on_reset) begin
      if (power_on_reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], 1'b0};
      end
   end

   // --------------------------------------------------------------------------
   // Divider and reset stretch registers
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge power_on_reset) begin
      if (power_on_reset) begin
         cnt_q     <= '0;
         n_q       <= DIV_DEFAULT;
         clk_q     <= 1'b0;
         clk_en_q  <= 1'b0;
         stretch_q <= '0;
         reset_q   <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         clk_q     <= clk_d;
         clk_en_q  <= clk_en_d;
         stretch_q <= stretch_d;
         reset_q   <= reset_d;
      end
   end

   // --------------------------------------------------------------------------
   // Divisor-change handshake with registered div_ack and locked
   // --------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge power_on_reset) begin
      if (power_on_reset) begin
         state_q   <= ST_IDLE;
         pend_q    <= DIV_DEFAULT;
         div_ack_q <= 1'b0;
         locked_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (div_req) begin
                  pend_q   <= sel_clamped;
                  state_q  <= ST_PEND;
                  locked_q <= 1'b0;
               end else begin
                  locked_q <= !reset_d;
               end
            end
            // A request dropped early still completes here; the ACK state
            // then returns to IDLE on the following edge.
            ST_PEND: begin
               locked_q <= 1'b0;
               if (load) begin
                  state_q   <= ST_ACK;
                  div_ack_q <= 1'b1;
               end
            end
            ST_ACK: begin
               if (!div_req) begin
                  state_q   <= ST_IDLE;
                  div_ack_q <= 1'b0;
                  locked_q  <= !reset_d;
               end else begin
                  locked_q  <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               div_ack_q <= 1'b0;
               locked_q  <= 1'b0;
            end
         endcase
      end
   end

   assign clk     = clk_q;
   assign clk_en  = clk_en_q;
   assign reset   = reset_q;
   assign div_ack = div_ack_q;
   assign locked  = locked_q;

endmodule

// File: tb/tb_clkrstgen.sv
// -----------------------------------------------------------------------------
// tb_clkrstgen -- self-checking bench for clkrstgen
//
// A behavioural model builds the expected clk/clk_en waveform one whole period
// at a time in a queue and tracks the handshake and reset stretch from the
// protocol rules; every CLK cycle the DUT outputs are compared against it.
// On top of that: directed reset/handshake sequences, a table of divisors with
// their expected high/low phase lengths, and randomized divisor requests.
// -----------------------------------------------------------------------------
module tb_clkrstgen;

   localparam int DIVBITS     = 8;
   localparam int DEFAULT_DIV = 4;
   localparam int RSTCYCLES   = 16;

   logic               CLK = 1'b0;
   logic               power_on_reset = 1'b0;
   logic [DIVBITS-1:0] div_sel;
   logic               div_req;
   logic               div_ack;
   logic               clk;
   logic               clk_en;
   logic               reset;
   logic               locked;

   clkrstgen #(
      .DIVBITS    (DIVBITS),
      .DEFAULT_DIV(DEFAULT_DIV),
      .RSTCYCLES  (RSTCYCLES)
   ) dut (
      .CLK           (CLK),
      .power_on_reset(power_on_reset),
      .div_sel       (div_sel),
      .div_req       (div_req),
      .div_ack       (div_ack),
      .clk           (clk),
      .clk_en        (clk_en),
      .reset         (reset),
      .locked        (locked)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   typedef enum {M_IDLE, M_WAIT, M_ACKD} mhs_e;

   mhs_e mst;
   int   m_n, m_pend, m_edges, m_pulses;
   bit   q_clk[$];
   bit   q_en[$];
   bit   e_clk, e_en, e_reset, e_ack, e_locked;

   // One full clk period of N CLK cycles: floor(N/2) high, rest low, enable
   // on the last cycle.
   function automatic void push_period(input int n);
      for (int i = 0; i < n; i++) begin
         q_clk.push_back(i < n / 2);
         q_en.push_back(i == n - 1);
      end
   endfunction

   always @(posedge CLK or posedge power_on_reset) begin
      if (power_on_reset) begin
         mst      = M_IDLE;
         m_n      = DEFAULT_DIV;
         m_pend   = 0;
         m_edges  = 0;
         m_pulses = 0;
         q_clk.delete();
         q_en.delete();
         // Reset state is position 0 of the first period; the remainder follows.
         push_period(m_n);
         void'(q_clk.pop_front());
         void'(q_en.pop_front());
         e_clk    = 1'b0;
         e_en     = 1'b0;
         e_reset  = 1'b1;
         e_ack    = 1'b0;
         e_locked = 1'b0;
      end else begin
         if (m_edges < 3) m_edges++;
         // From the third edge after release the synchroniser reads 0;
         // each edge ending a clk_en cycle is one counted clk rise.
         if (e_reset && m_edges >= 3 && e_en) begin
            m_pulses++;
            if (m_pulses == RSTCYCLES) e_reset = 1'b0;
         end
         case (mst)
            M_IDLE: if (div_req) begin
               m_pend = (div_sel < 2) ? 2 : int'(div_sel);
               mst    = M_WAIT;
            end
            M_WAIT: if (e_en) begin
               m_n = m_pend;
               mst = M_ACKD;
            end
            M_ACKD: if (!div_req) mst = M_IDLE;
            default: mst = M_IDLE;
         endcase
         if (q_clk.size() == 0) push_period(m_n);
         e_clk    = q_clk.pop_front();
         e_en     = q_en.pop_front();
         e_ack    = (mst == M_ACKD);
         e_locked = !e_reset && (mst == M_IDLE);
      end
   end

   bit chk_on = 1'b0;

   always @(negedge CLK) begin
      if (chk_on) begin
         check_int($sformatf("cycle_t%0t", $time),
                   int'({clk, clk_en, reset, div_ack, locked}),
                   int'({e_clk, e_en, e_reset, e_ack, e_locked}));
      end
   end

   // ---------------------------------------------------------------------------
   // Helpers (all called at a falling CLK edge)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic count_release(output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (reset && n < 2000);
   endtask

   // Measures the next complete clk period; -1 means no clk activity.
   task automatic measure(output int hi, output int lo);
      int   guard;
      logic prev;
      hi    = 0;
      lo    = 0;
      guard = 0;
      do begin
         prev = clk;
         tick();
         guard++;
      end while (!(prev == 1'b0 && clk == 1'b1) && guard < 1000);
      while (clk && guard < 1000) begin
         hi++;
         tick();
         guard++;
      end
      while (!clk && guard < 1000) begin
         lo++;
         tick();
         guard++;
      end
      if (guard >= 1000) begin
         hi = -1;
         lo = -1;
      end
   endtask

   task automatic wait_en();
      int guard = 0;
      while (!clk_en && guard < 1000) begin
         tick();
         guard++;
      end
      check_bit("wait_clk_en", clk_en, 1'b1);
   endtask

   task automatic change_div(input int sel, input string tag);
      int guard = 0;
      div_sel = DIVBITS'(sel);
      div_req = 1'b1;
      while (!div_ack && guard < 2000) begin
         tick();
         guard++;
      end
      check_bit({tag, "_ack_rise"}, div_ack, 1'b1);
      div_req = 1'b0;
      tick();
      check_bit({tag, "_ack_fall"}, div_ack, 1'b0);
   endtask

   typedef struct {
      int sel;
      int hi;
      int lo;
   } vec_t;

   // ---------------------------------------------------------------------------
   // Test sequence
   // ---------------------------------------------------------------------------
   initial begin
      vec_t vecs[9];
      int   n, hi, lo, pulses, k;
      bit   acked;
      logic [6:0] bits;

      vecs[0] = '{5,   2,   3};
      vecs[1] = '{0,   1,   1};
      vecs[2] = '{1,   1,   1};
      vecs[3] = '{255, 127, 128};
      vecs[4] = '{3,   1,   2};
      vecs[5] = '{9,   4,   5};
      vecs[6] = '{2,   1,   1};
      vecs[7] = '{4,   2,   2};
      vecs[8] = '{4,   2,   2};

      div_req = 1'b0;
      div_sel = DIVBITS'(DEFAULT_DIV);
      #1 power_on_reset = 1'b1;
      #20;

      // Reset state
      check_bit("rst_clk",     clk,     1'b0);
      check_bit("rst_clk_en",  clk_en,  1'b0);
      check_bit("rst_reset",   reset,   1'b1);
      check_bit("rst_div_ack", div_ack, 1'b0);
      check_bit("rst_locked",  locked,  1'b0);
      chk_on = 1'b1;

      // Release: first counted clk_en pulse ends on edge 4, the 16th on edge 64.
      tick();
      #2 power_on_reset = 1'b0;
      count_release(n);
      check_int("release_cycles", n, DEFAULT_DIV * RSTCYCLES);
      check_bit("release_locked", locked, 1'b1);
      check_bit("release_clk_rise", clk, 1'b1);
      measure(hi, lo);
      check_int("default_hi", hi, 2);
      check_int("default_lo", lo, 2);

      // Mid-period change to 7, raised at cnt = 1
      wait_en();
      tick();
      tick();
      check_bit("mid_cnt1_clk", clk, 1'b1);
      div_sel = 8'd7;
      div_req = 1'b1;
      tick();
      check_bit("mid_locked_low", locked, 1'b0);
      check_bit("mid_ack_low", div_ack, 1'b0);
      check_bit("mid_old_cnt2_clk", clk, 1'b0);
      tick();
      check_bit("mid_old_cnt3_en", clk_en, 1'b1);
      check_bit("mid_old_cnt3_clk", clk, 1'b0);
      tick();
      check_bit("mid_ack_at_boundary", div_ack, 1'b1);
      bits[0] = clk;
      div_req = 1'b0;
      for (int i = 1; i < 7; i++) begin
         tick();
         bits[i] = clk;
         if (i == 1) begin
            check_bit("mid_ack_drop", div_ack, 1'b0);
            check_bit("mid_locked_back", locked, 1'b1);
         end
         if (i == 6) check_bit("mid_new_en", clk_en, 1'b1);
      end
      check_int("mid_new_wave", int'(bits), int'(7'b0000111));

      // Divisor table
      foreach (vecs[i]) begin
         change_div(vecs[i].sel, $sformatf("tbl%0d", i));
         measure(hi, lo);
         check_int($sformatf("tbl%0d_hi", i), hi, vecs[i].hi);
         check_int($sformatf("tbl%0d_lo", i), lo, vecs[i].lo);
      end

      // Async reset while a change to 9 is pending
      wait_en();
      tick();
      div_sel = 8'd9;
      div_req = 1'b1;
      tick();
      check_bit("pend_locked_low", locked, 1'b0);
      check_bit("pend_clk_high", clk, 1'b1);
      #2 power_on_reset = 1'b1;
      #1;
      check_bit("abort_reset",   reset,   1'b1);
      check_bit("abort_clk",     clk,     1'b0);
      check_bit("abort_div_ack", div_ack, 1'b0);
      check_bit("abort_clk_en",  clk_en,  1'b0);
      div_req = 1'b0;
      tick();
      tick();
      #2 power_on_reset = 1'b0;
      count_release(n);
      check_int("abort_release_cycles", n, DEFAULT_DIV * RSTCYCLES);
      measure(hi, lo);
      check_int("abort_hi", hi, 2);
      check_int("abort_lo", lo, 2);

      // Change to 3 issued during the reset stretch
      tick();
      #2 power_on_reset = 1'b1;
      tick();
      #2 power_on_reset = 1'b0;
      pulses = 0;
      acked  = 1'b0;
      k      = 0;
      while (k < 2000) begin
         tick();
         k++;
         if (!reset) break;
         if (k >= 2 && clk_en) pulses++;
         if (k == 3) begin
            div_sel = 8'd3;
            div_req = 1'b1;
         end
         if (div_req && div_ack) begin
            div_req = 1'b0;
            acked   = 1'b1;
         end
      end
      check_int("stretch_pulses", pulses, RSTCYCLES);
      check_bit("stretch_acked", acked, 1'b1);
      check_bit("stretch_clk_rise", clk, 1'b1);
      // Two N=4 pulses, then the rest at N=3.
      check_int("stretch_cycles", k, 2 * DEFAULT_DIV + (RSTCYCLES - 2) * 3);
      measure(hi, lo);
      check_int("stretch_hi", hi, 1);
      check_int("stretch_lo", lo, 2);

      // Randomized requests, checked cycle by cycle against the model
      for (int it = 0; it < 40; it++) begin
         int sel;
         repeat ($urandom_range(0, 9)) tick();
         sel = $urandom_range(0, 12);
         if ($urandom_range(0, 4) == 0) begin
            // Request dropped before acknowledge: change must still complete.
            div_sel = DIVBITS'(sel);
            div_req = 1'b1;
            tick();
            div_req = 1'b0;
            repeat (30) tick();
         end else begin
            change_div(sel, $sformatf("rnd%0d", it));
         end
         if ($urandom_range(0, 9) == 0) begin
            #2 power_on_reset = 1'b1;
            tick();
            #2 power_on_reset = 1'b0;
            tick();
         end
      end

      repeat (5) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
